// File: rtl/ir_tx_scheduler.sv
// Round-robin scheduler sharing one IR encoder among up to four command sources.
// Each grant latches one command, replays it rpt+1 times, and a watchdog aborts stuck frames.
module ir_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_cmd,
  input  logic [4*NUM_REQ-1:0]   req_rpt,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            enc_cmd,
  output logic                   enc_valid,
  input  logic                   enc_ready,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [31:0]         cmd_q, cmd_d;
  logic [3:0]          rpt_q, rpt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                vld_q, vld_d;
  logic                terr_q, terr_d;

  logic [3:0]          req_pad;
  logic [2:0]          idx;
  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [31:0]         sel_cmd;
  logic [3:0]          sel_rpt;

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == {WD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] g);
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == 2'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Search upward from the last owner so the previous winner has lowest priority.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req_valid;
    pick_found = 1'b0;
    pick_idx   = grant_q;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, grant_q} + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!pick_found && req_pad[idx[1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = idx[1:0];
      end
    end
    sel_cmd = '0;
    sel_rpt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_cmd = req_cmd[32*i +: 32];
        sel_rpt = req_rpt[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    rpt_d   = rpt_q;
    wd_d    = wd_q;
    ack_d   = '0;
    done_d  = '0;
    vld_d   = 1'b0;
    terr_d  = err_clr ? 1'b0 : terr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cmd_d   = sel_cmd;
          rpt_d   = sel_rpt;
          ack_d   = onehot(pick_idx);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (enc_ready) begin
          vld_d   = 1'b1;
          wd_d    = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        wd_d = wd_sat_inc(wd_q);
        // Watchdog abort takes priority over a completion seen in the same cycle.
        if (wd_q == WD_LIMIT) begin
          terr_d  = 1'b1;
          done_d  = onehot(grant_q);
          rpt_d   = '0;
          state_d = IDLE;
        end else if (state_q == WAIT_BUSY) begin
          if (!enc_ready) state_d = WAIT_DONE;
        end else if (enc_ready) begin
          if (rpt_q == 4'd0) begin
            done_d  = onehot(grant_q);
            state_d = IDLE;
          end else begin
            rpt_d   = rpt_q - 4'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'(NUM_REQ - 1);
      cmd_q   <= '0;
      rpt_q   <= '0;
      wd_q    <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      vld_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      rpt_q   <= rpt_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      terr_q  <= terr_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign enc_cmd     = cmd_q;
  assign enc_valid   = vld_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler; enc_ready is driven step by step to mimic the encoder.
module tb_ir_tx_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_cmd;
  logic [15:0]  req_rpt;
  logic [3:0]   req_ack;
  logic [3:0]   req_done;
  logic [31:0]  enc_cmd;
  logic         enc_valid;
  logic         enc_ready;
  logic         busy;
  logic [1:0]   grant_id;
  logic         timeout_err;
  logic         err_clr;

  int ncmp = 0;
  int nerr = 0;
  int nvld = 0;
  int nack = 0;
  int ndone = 0;
  int viol = 0;
  logic prev_vld = 1'b0;
  logic [31:0] rr_cmd [4];
  int rr_order [6];

  ir_tx_scheduler #(.NUM_REQ(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_rpt(req_rpt), .req_ack(req_ack), .req_done(req_done),
    .enc_cmd(enc_cmd), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (enc_valid) begin
      nvld++;
      if (prev_vld || !enc_ready) viol++;
    end
    prev_vld = enc_valid;
    nack  += $countones(req_ack);
    ndone += $countones(req_done);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after the enc_valid pulse: encoder accepts, stays busy len cycles, raises ready.
  task automatic do_frame(input int len);
    tick();
    enc_ready = 1'b0;
    repeat (len) tick();
    enc_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_rpt = '0;
    enc_ready = 1'b1; err_clr = 1'b0;
    rr_cmd[0] = 32'h1111_0000; rr_cmd[1] = 32'h2222_0001;
    rr_cmd[2] = 32'h3333_0002; rr_cmd[3] = 32'h4444_0003;
    rr_order[0] = 3; rr_order[1] = 0; rr_order[2] = 1;
    rr_order[3] = 2; rr_order[4] = 3; rr_order[5] = 0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd3);
    check("rst_cmd", enc_cmd, 32'd0);
    check("rst_valid", 32'(enc_valid), 32'd0);
    check("rst_ack_done", {24'd0, req_ack, req_done}, 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single request, no repeats
    nvld = 0; nack = 0; ndone = 0;
    req_cmd[31:0] = 32'hA5A5_00FF; req_rpt[3:0] = 4'd0; req_valid = 4'b0001;
    tick();
    check("s_ack", 32'(req_ack), 32'h1);
    check("s_busy", 32'(busy), 32'd1);
    check("s_cmd", enc_cmd, 32'hA5A5_00FF);
    check("s_grant", 32'(grant_id), 32'd0);
    check("s_novld_yet", 32'(enc_valid), 32'd0);
    req_valid = 4'b0000;
    tick();
    check("s_vld", 32'(enc_valid), 32'd1);
    check("s_ack_gone", 32'(req_ack), 32'd0);
    do_frame(6);
    check("s_busy_frame", 32'(busy), 32'd1);
    check("s_nodone_early", 32'(req_done), 32'd0);
    tick();
    check("s_done", 32'(req_done), 32'h1);
    check("s_idle", 32'(busy), 32'd0);
    tick(); tick();
    check("s_done_pulse", 32'(req_done), 32'd0);
    check("s_nvld", 32'(nvld), 32'd1);
    check("s_nack_ndone", 32'(nack * 16 + ndone), 32'h11);

    // Three extra repeats from requester 2
    nvld = 0; nack = 0; ndone = 0;
    req_cmd[95:64] = 32'h1234_5678; req_rpt[11:8] = 4'd3; req_valid = 4'b0100;
    tick();
    check("r_ack", 32'(req_ack), 32'h4);
    check("r_grant", 32'(grant_id), 32'd2);
    req_valid = 4'b0000; req_cmd[95:64] = 32'hDEAD_BEEF; req_rpt[11:8] = 4'd0;
    tick();
    for (int r = 0; r < 4; r++) begin
      check("r_vld", 32'(enc_valid), 32'd1);
      check("r_cmd_stable", enc_cmd, 32'h1234_5678);
      do_frame(5);
      tick();
      if (r < 3) begin
        check("r_gap", 32'(enc_valid), 32'd0);
        check("r_nodone", 32'(req_done), 32'd0);
        tick();
      end else begin
        check("r_done", 32'(req_done), 32'h4);
        check("r_idle", 32'(busy), 32'd0);
      end
    end
    repeat (4) tick();
    check("r_nvld", 32'(nvld), 32'd4);
    check("r_ndone", 32'(ndone), 32'd1);

    // Round robin with all requesters held high; last owner was 2
    nack = 0; ndone = 0;
    for (int i = 0; i < 4; i++) begin
      req_cmd[32*i +: 32] = rr_cmd[i];
      req_rpt[4*i +: 4] = 4'd0;
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("rr_ack", 32'(req_ack), 32'(1 << rr_order[n]));
      check("rr_grant", 32'(grant_id), 32'(rr_order[n]));
      check("rr_cmd", enc_cmd, rr_cmd[rr_order[n]]);
      tick();
      check("rr_vld", 32'(enc_valid), 32'd1);
      do_frame(3);
      tick();
      check("rr_done", 32'(req_done), 32'(1 << rr_order[n]));
    end
    req_valid = 4'b0000;
    tick(); tick();
    check("rr_counts", 32'(nack * 16 + ndone), 32'h66);

    // Mid-frame reset in WAIT_DONE with repeats pending
    req_rpt[7:4] = 4'd2; req_valid = 4'b0010;
    tick();
    check("m_grant", 32'(grant_id), 32'd1);
    req_valid = 4'b0000;
    tick();
    check("m_vld", 32'(enc_valid), 32'd1);
    tick();
    enc_ready = 1'b0;
    tick(); tick();
    ndone = 0;
    rst = 1'b1; enc_ready = 1'b1;
    #1;
    check("m_busy", 32'(busy), 32'd0);
    check("m_grant_rst", 32'(grant_id), 32'd3);
    check("m_cmd", enc_cmd, 32'd0);
    tick();
    check("m_no_done", 32'(req_done), 32'd0);
    rst = 1'b0;
    tick();
    check("m_ndone", 32'(ndone), 32'd0);

    // Simultaneous 1010 after reset: 1 first, then 3
    req_rpt = '0; req_valid = 4'b1010;
    tick();
    check("p_ack1", 32'(req_ack), 32'h2);
    check("p_cmd1", enc_cmd, rr_cmd[1]);
    tick();
    do_frame(3);
    tick();
    check("p_done1", 32'(req_done), 32'h2);
    tick();
    check("p_ack3", 32'(req_ack), 32'h8);
    check("p_grant3", 32'(grant_id), 32'd3);
    req_valid = 4'b0000;
    tick();
    do_frame(2);
    tick();
    check("p_done3", 32'(req_done), 32'h8);

    // Watchdog with an encoder that never hands back ready
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    check("w_vld", 32'(enc_valid), 32'd1);
    tick();
    enc_ready = 1'b0;
    repeat (98) tick();
    check("w_not_yet", 32'(timeout_err), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    tick();
    check("w_terr", 32'(timeout_err), 32'd1);
    check("w_done", 32'(req_done), 32'h1);
    check("w_idle", 32'(busy), 32'd0);
    tick();
    check("w_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("w_clr", 32'(timeout_err), 32'd0);

    // Clear and new timeout in the same cycle: set wins
    enc_ready = 1'b1; req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    enc_ready = 1'b0;
    repeat (98) tick();
    check("w2_not_yet", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("w2_set_wins", 32'(timeout_err), 32'd1);
    check("w2_done", 32'(req_done), 32'h1);
    tick();
    check("w2_sticky", 32'(timeout_err), 32'd1);

    check("vld_protocol", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ir_tx_scheduler.md
# ir_tx_scheduler

Round-robin scheduler that shares one `ir_encoder` transmitter among up to four command sources, such as the front-panel, UART bridge and test-pattern logic. It latches one 32-bit command per grant and replays it a per-request number of times. It drives the encoder's `cmd`/`valid`/`ready` handshake and reports completion back to the owning requester. A watchdog aborts the frame if the encoder fails to hand back `ready`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..4.
- `TIMEOUT`, 8_000_000: watchdog limit in clk cycles, counted per frame. The worst-case encoder frame is about 4.1M cycles at 25 MHz.

Ports:
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_cmd`  in  32*NUM_REQ  command for requester i, in bits [32i+31:32i].
- `req_rpt`  in  4*NUM_REQ  extra repeats for requester i, in bits [4i+3:4i]; 0 means send once.
- `req_ack`  out  NUM_REQ  one-cycle pulse: request latched, requester may change its inputs.
- `req_done`  out  NUM_REQ  one-cycle pulse: all frames for this grant finished or were aborted.
- `enc_cmd`  out  32  to the encoder `cmd` input.
- `enc_valid`  out  1  to the encoder `valid` input; always a single-cycle pulse.
- `enc_ready`  in  1  from the encoder `ready` output.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  2  index of the current or last owner.
- `timeout_err`  out  1  sticky watchdog flag.
- `err_clr`  in  1  synchronous clear for `timeout_err`.

## Operation
- All outputs reset to 0, except `grant_id`, which resets to NUM_REQ-1 so that requester 0 has first priority.
- Internal state at reset: `rpt_left`=0, `wd_cnt`=0, state IDLE.
- States and transitions:
  - IDLE: if any `req_valid` is set, pick the first set bit searching upward (with wrap) from `grant_id+1`. Latch `req_cmd` into `enc_cmd` and `req_rpt` into `rpt_left`, update `grant_id`, pulse `req_ack[g]`, and go to ISSUE.
  - ISSUE: when `enc_ready`=1, pulse `enc_valid`, clear `wd_cnt`, and go to WAIT_BUSY. If `enc_ready`=0, wait here; the watchdog is not running in this state.
  - WAIT_BUSY: `enc_valid`=0. When `enc_ready`=0, go to WAIT_DONE.
  - WAIT_DONE: when `enc_ready`=1 and `rpt_left`=0, pulse `req_done[g]` and go to IDLE. When `enc_ready`=1 and `rpt_left`>0, decrement `rpt_left` and go to ISSUE.
- Watchdog:
  - `wd_cnt` increments every cycle in WAIT_BUSY and WAIT_DONE and saturates.
  - When `wd_cnt` reaches TIMEOUT-1, set `timeout_err`, pulse `req_done[g]`, discard `rpt_left`, and go to IDLE.
- `enc_cmd` holds its value until the next grant. The encoder latches it on its accept edge, and `enc_cmd` stays stable across repeats.
- `req_valid` still high after its own `req_done` counts as a new request. That requester then has lowest priority, so other requesters are not starved.
- `req_valid` dropped after `req_ack` has no effect on the transmission in progress.
- `err_clr` and a new timeout in the same cycle: set wins.
- Reset mid-frame returns every output to its reset value immediately. No `req_done` is issued for the aborted grant.

## Timing
- Request path: `req_valid` sampled high in IDLE at edge N. After edge N+1, `req_ack`, `busy` and `enc_cmd` are valid. The `enc_valid` pulse follows after edge N+2 if `enc_ready`=1. The encoder drops `ready` at edge N+3.
- Accept-to-done: `enc_ready` rises at edge M in WAIT_DONE. `req_done` pulses after edge M+1, and IDLE is reached at the same edge.
- Repeat path: `enc_ready` rising leads to the next `enc_valid` after 2 edges.
- `enc_valid` is never asserted while `enc_ready`=0 and is never high on two consecutive cycles, so the encoder cannot double-accept a command.
- Arbitration is evaluated only in IDLE; requests arriving mid-grant wait.
- The watchdog measures from the `enc_valid` pulse and covers both wait states.

## Test plan
- Single request: `req_valid[0]`, `cmd`=0xA5A5_00FF, `rpt`=0 → one `req_ack[0]` and one `enc_valid`, with `enc_cmd`=0xA5A5_00FF. `req_done[0]` pulses 1 cycle after the encoder ready rises. `busy` then falls.
- Repeats: `rpt`=3, using a real `ir_encoder` with shortened parameters → exactly 4 `enc_valid` pulses with identical `enc_cmd`, and exactly one `req_done`.
- Round-robin fairness: all 4 `req_valid` held high → grant order 0,1,2,3,0,1 …, with exactly one `req_ack` and one `req_done` per grant.
- Simultaneous requests after reset: `req_valid`=4'b1010 → requester 1 is granted first, then requester 3.
- Watchdog: TIMEOUT=100, with an encoder model that never raises `ready` → `timeout_err` set 100 cycles after `enc_valid`, `req_done` pulses, and the FSM returns to IDLE. `err_clr` then clears the flag. With `err_clr` and a timeout in the same cycle, the flag stays set.
- Mid-frame reset: assert `rst` in WAIT_DONE with `rpt_left`=2 → all outputs 0, `grant_id`=3, no `req_done`. After release, the next request is serviced normally.
